bcd_to_binary_seq: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the display path's binary-to-BCD (double-dabble) conversion. It accepts a packed 4-digit BCD value on a start strobe and returns the equivalent unsigned binary value after a fixed number of cycles, using reverse double dabble (shift right, then subtract 3 from each digit ≥ 8). It sits between BCD-entry logic (switches or keypad digits) and the binary arithmetic and VGA/counter logic.

---
 rtl/bcd_to_binary_seq.sv | 186 ++++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_binary_seq
// Purpose  : Sequential BCD-to-binary converter using reverse double dabble.
//            A packed DIGITS-digit BCD value is captured on an accepted start
//            and the unsigned binary equivalent is produced after a fixed
//            4*DIGITS cycles. Each cycle shifts the digit register right into
//            the result register, then subtracts 3 from every digit that
//            became >= 8.
//
// Ports    : clk       in   system clock, rising edge
//            rst_n     in   asynchronous active-low reset
//            i_start   in   conversion request, sampled only while idle
//            i_bcd     in   packed BCD, most significant digit in top nibble
//            o_busy    out  high while a conversion is in progress
//            o_done    out  one-cycle pulse, o_binary/o_error valid with it
//            o_binary  out  result, held until the next conversion completes
//            o_error   out  an input digit was > 9 (checked build only)
//
// Options  : BCD2BIN_ERRCHK_EN - when defined, input digits are range-checked
//            on acceptance; an invalid input reports o_error=1 and forces
//            o_binary to 0. When undefined, o_error is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [4*DIGITS-1:0]   i_bcd,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [BIN_W-1:0]      o_binary,
   output logic                  o_error
);

   localparam int c_BCD_W = 4 * DIGITS;
   localparam int c_CNT_W = $clog2(c_BCD_W);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   w_load;
   logic                   w_shift;
   logic                   w_last;

   logic [c_BCD_W-1:0]     r_d;
   // The bit that would land in position 0 of the shift register arrives
   // only on the final shift and goes straight into o_binary, so the
   // register itself never needs to hold it.
   logic [c_BCD_W-1:1]     r_b;
   logic [c_CNT_W-1:0]     r_cnt;
   logic                   r_done;
   logic [BIN_W-1:0]       r_binary;

   logic [c_BCD_W-1:0]     w_b_next;
   logic [c_BCD_W-1:0]     w_d_shr;
   logic [c_BCD_W-1:0]     w_d_adj;
   logic [BIN_W-1:0]       w_result;

   // ------------------------------------------------------------------------
   // Datapath: shift one bit of the digit register into the result register,
   // then correct each digit that now reads >= 8 (a borrowed 10 halved to 5,
   // seen as 8, must become 5: subtract 3). Correction is per nibble with no
   // borrow between digits.
   // ------------------------------------------------------------------------
   assign w_b_next = {r_d[0], r_b};
   assign w_d_shr  = r_d >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      logic [3:0] w_nib;
      assign w_nib                = w_d_shr[4*g +: 4];
      assign w_d_adj[4*g +: 4]    = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
   end

   // ------------------------------------------------------------------------
   // Control FSM: next state and control strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_load       = 1'b1;
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == c_CNT_W'(c_BCD_W - 1)) begin
               w_last       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Optional input range check
   // ------------------------------------------------------------------------
`ifdef BCD2BIN_ERRCHK_EN
   logic [DIGITS-1:0] w_nib_bad;
   logic              r_err_flag;
   logic              r_error;

   for (genvar g = 0; g < DIGITS; g++) begin : g_chk
      assign w_nib_bad[g] = (i_bcd[4*g +: 4] > 4'd9);
   end

   // Flag is captured at acceptance so the input may change mid-conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_flag <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         if (w_load) begin
            r_err_flag <= |w_nib_bad;
         end
         if (w_last) begin
            r_error <= r_err_flag;
         end
      end
   end

   assign w_result = r_err_flag ? '0 : w_b_next[BIN_W-1:0];
   assign o_error  = r_error;
`else
   assign w_result = w_b_next[BIN_W-1:0];
   assign o_error  = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Working registers and result
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_binary <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_d   <= i_bcd;
            r_b   <= '0;
            r_cnt <= '0;
         end else if (w_shift) begin
            r_d   <= w_d_adj;
            r_b   <= w_b_next[c_BCD_W-1:1];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_binary <= w_result;
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign o_busy   = (r_state == S_SHIFT);
   assign o_done   = r_done;
   assign o_binary = r_binary;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_binary_seq
// Purpose  : Self-checking bench for bcd_to_binary_seq. Each accepted start
//            pushes the expected result and completion cycle to a queue; a
//            monitor pops and compares on every done pulse. An unexpected
//            done is an error.
// Options  : BCD2BIN_ERRCHK_EN - also exercises the invalid-digit path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_seq;

   typedef struct {
      logic [13:0] bin;
      logic        err;
      logic        chk_bin;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] bcd;
   logic        busy;
   logic        done;
   logic [13:0] binary;
   logic        error;

   int   cyc;
   int   n_checks;
   int   n_errors;
   exp_t sbq[$];
   exp_t m_e;

   bcd_to_binary_seq #(
      .DIGITS (4),
      .BIN_W  (14)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (start),
      .i_bcd    (bcd),
      .o_busy   (busy),
      .o_done   (done),
      .o_binary (binary),
      .o_error  (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done cyc=%0d binary=%0d", cyc, binary);
         end else begin
            m_e = sbq.pop_front();
            n_checks++;
            if (cyc !== m_e.due) begin
               n_errors++;
               $display("FAIL done_latency got_cycle=%0d want_cycle=%0d", cyc, m_e.due);
            end
            n_checks++;
            if (error !== m_e.err) begin
               n_errors++;
               $display("FAIL error_flag got=%0b want=%0b", error, m_e.err);
            end
            n_checks++;
            if (busy !== 1'b0) begin
               n_errors++;
               $display("FAIL busy_at_done got=%0b want=0", busy);
            end
            if (m_e.chk_bin) begin
               n_checks++;
               if (binary !== m_e.bin) begin
                  n_errors++;
                  $display("FAIL binary got=%0d want=%0d", binary, m_e.bin);
               end
            end
         end
      end
   end

   // Drive a one-cycle start and record the expectation. Called between edges.
   task automatic issue_start(input logic [15:0] v, input logic [13:0] eb,
                              input logic ee, input logic cb);
      exp_t e;
      e.bin     = eb;
      e.err     = ee;
      e.chk_bin = cb;
      e.due     = cyc + 17;
      sbq.push_back(e);
      start = 1'b1;
      bcd   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      bcd   = 16'($urandom);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (sbq.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      bcd   = 16'h0000;
      #3;
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%0b want=0", done); end
      n_checks++;
      if (binary !== 14'd0) begin n_errors++; $display("FAIL reset_binary got=%0d want=0", binary); end
      n_checks++;
      if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error got=%0b want=0", error); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [15:0] vals [3] = '{16'h1234, 16'h9999, 16'h0000};
      logic [13:0] exps [3] = '{14'd1234, 14'd9999, 14'd0};
      for (int i = 0; i < 3; i++) begin
         issue_start(vals[i], exps[i], 1'b0, 1'b1);
         n_checks++;
         if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_accept got=%0b want=1", busy);
         end
         wait_drain();
      end
   endtask

   task automatic test_random_valid();
      for (int i = 0; i < 4; i++) begin
         int d3, d2, d1, d0;
         d3 = $urandom_range(0, 9);
         d2 = $urandom_range(0, 9);
         d1 = $urandom_range(0, 9);
         d0 = $urandom_range(0, 9);
         issue_start({4'(d3), 4'(d2), 4'(d1), 4'(d0)},
                     14'(d3 * 1000 + d2 * 100 + d1 * 10 + d0), 1'b0, 1'b1);
         wait_drain();
      end
   endtask

   task automatic test_busy_ignore();
      issue_start(16'h0042, 14'd42, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      bcd   = 16'h5555;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1;
      bcd   = 16'h5555;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();
      repeat (20) @(negedge clk);
      n_checks++;
      if (binary !== 14'd42) begin
         n_errors++;
         $display("FAIL ignored_start_binary got=%0d want=42", binary);
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      seen = 1'b0;
      issue_start(16'h0100, 14'd100, 1'b0, 1'b1);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL b2b_first_done got=0 want=1");
      end else begin
         issue_start(16'h0007, 14'd7, 1'b0, 1'b1);
      end
      wait_drain();
   endtask

   task automatic test_error();
`ifdef BCD2BIN_ERRCHK_EN
      issue_start(16'h12A4, 14'd0, 1'b1, 1'b1);
      wait_drain();
      issue_start(16'h0010, 14'd10, 1'b0, 1'b1);
      wait_drain();
`else
      issue_start(16'h12A4, 14'd0, 1'b0, 1'b0);
      wait_drain();
      issue_start(16'h0010, 14'd10, 1'b0, 1'b1);
      wait_drain();
`endif
   endtask

   task automatic test_reset_abort();
      issue_start(16'h0321, 14'd321, 1'b0, 1'b1);
      wait_drain();
      start = 1'b1;
      bcd   = 16'h0500;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done got=%0b want=0", done); end
      n_checks++;
      if (binary !== 14'd0) begin n_errors++; $display("FAIL abort_binary got=%0d want=0", binary); end
      n_checks++;
      if (error !== 1'b0) begin n_errors++; $display("FAIL abort_error got=%0b want=0", error); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue_start(16'h0500, 14'd500, 1'b0, 1'b1);
      wait_drain();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_basic();
      test_random_valid();
      test_busy_ignore();
      test_back_to_back();
      test_error();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout cyc=%0d want=finish", cyc);
      $fatal(1);
   end

endmodule
`default_nettype wire
